alu_ctl_divu_seq: RTL

- Producer side of the 3-bit ALU slice control interface.
- Decodes the main-control ALUOp and R-type funct into the ctl code that drives every ALU slice.
- Owns a multi-cycle restoring DIVU sequencer that produces HI/LO with a start/busy/done handshake.
- Sits between main control (decode stage) and the 32-slice ALU and HI/LO registers of the MIPS datapath.

---
 rtl/alu_ctl_divu_seq_if.sv | 30 +++
 rtl/alu_ctl_divu_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_ctl_divu_seq_if.sv
// alu_ctl_divu_seq_if: bundle between main control / HI-LO registers and the ALU control block.
//   master : main control side. It drives alu_op, funct, start, dividend and divisor, and
//            observes ctl, illegal, busy, done, div_zero, hi and lo.
//   slave  : alu_ctl_divu_seq side, with the opposite directions.
interface alu_ctl_divu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [2:0]       ctl;
  logic             illegal;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_op, funct, start, dividend, divisor,
    input  ctl, illegal, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  alu_op, funct, start, dividend, divisor,
    output ctl, illegal, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_ctl_divu_seq.sv
// alu_ctl_divu_seq: decodes ALUOp/funct into the 3-bit ALU slice control code and runs a
// multi-cycle restoring unsigned divider that writes HI (remainder) and LO (quotient).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of alu_ctl_divu_seq_if
//           in : alu_op, funct, start, dividend, divisor
//           out: ctl, illegal, busy, done, div_zero, hi, lo
module alu_ctl_divu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  alu_ctl_divu_seq_if.slave bus
);

  localparam logic [5:0] FunctDivu = 6'b011011;

  typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div_zero;

  logic             w_accept, w_last, w_borrow;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  logic [2:0]       w_dec_ctl;
  logic             w_dec_illegal;

  assign w_accept = (r_state == StIdle) && bus.start && (bus.alu_op == 2'b10) &&
                    (bus.funct == FunctDivu);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Trial subtract on the shifted partial remainder. Because rem < divisor always holds, the
  // difference lies in (-2^WIDTH, 2^WIDTH), so the top bit is a reliable borrow flag.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_borrow  = w_trial[WIDTH];
  assign w_rem_nxt = w_borrow ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_nxt = (bus.divisor == '0) ? StZero : StRun;
      StRun:  if (w_last) w_state_nxt = StDone;
      StZero: w_state_nxt = StDone;
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Divider datapath; hi/lo only change when a result is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_rem      <= '0;
      r_quo      <= bus.dividend;
      r_dvs      <= bus.divisor;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
    end else if (r_state == StRun) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_hi <= w_rem_nxt;
        r_lo <= w_quo_nxt;
      end
    end else if (r_state == StZero) begin
      // r_quo still holds the dividend untouched
      r_lo       <= '1;
      r_hi       <= r_quo;
      r_div_zero <= 1'b1;
    end
  end

  // ALUOp / funct decode
  always_comb begin
    w_dec_ctl     = 3'b010;
    w_dec_illegal = 1'b0;
    unique case (bus.alu_op)
      2'b00: w_dec_ctl = 3'b010;
      2'b01: w_dec_ctl = 3'b110;
      2'b10: begin
        unique case (bus.funct)
          6'b100000, 6'b100001: w_dec_ctl = 3'b010;
          6'b100010, 6'b100011: w_dec_ctl = 3'b110;
          6'b100100:            w_dec_ctl = 3'b000;
          6'b100101:            w_dec_ctl = 3'b001;
          6'b101010:            w_dec_ctl = 3'b111;
          FunctDivu:            w_dec_ctl = 3'b010;
          default:              w_dec_illegal = 1'b1;
        endcase
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // Outputs; while dividing the slices are forced to subtract
  always_comb begin
    bus.ctl     = w_dec_ctl;
    bus.illegal = w_dec_illegal;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (r_state)
      StRun, StZero: begin
        bus.busy    = 1'b1;
        bus.ctl     = 3'b110;
        bus.illegal = 1'b0;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.div_zero = r_div_zero;

endmodule
